// File: rtl/gamma_share_pkg.sv
// rtl/gamma_share_pkg.sv - shared constants and types for the gamma sharing controller
package gamma_share_pkg;

  localparam int DATA_W = 128;
  localparam int BYTE_N = 16;

  localparam logic OWNER_RND = 1'b0;
  localparam logic OWNER_KEY = 1'b1;

  typedef logic [DATA_W-1:0] blk_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/gamma.sv
// rtl/gamma.sv - Anubis gamma layer: the involutive 8-bit S-box applied to all 16 bytes
module gamma
  import gamma_share_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Element 0 is the leftmost byte of the concatenation; row n covers inputs 0xn0..0xnF.
  localparam logic [0:255][7:0] SBOX = {
    128'ha7d3e671d0ac4d793ac991fc1e4754bd,
    128'h8ca57afb63b8ddd4e5b3c5bea9880ca2,
    128'h39df29da2ba8cb4c4b22aa244170a6f9,
    128'h5ae2b0367de433ff6020088b5eab7f78,
    128'h7c2c57d2dc6d7e0d5394c32827065fad,
    128'h675c55480e52ea425b5d305851593c4e,
    128'h388a7214e7c6de508e92d17793459ace,
    128'h2d0362b6b9bf966b3f0712ae4034463e,
    128'hdbcfecccc1a1c0d61df4613b10d868a0,
    128'hb10a696c49fa76c49e9b6e99c2b798bc,
    128'h8f851fb4f8112e00251c2a3d054f7bb2,
    128'h3290af19a3f7739d1574eeca9f0f1b75,
    128'h86849c4a971a65f6ed09bb2683eb6f81,
    128'h046a430117e187f58de3238044166621,
    128'hfed531d935180264f2f156cd82c8baf0,
    128'hefe9e8fd89d7c7b5a42f95130bf3e037
  };

  always_comb begin
    dout = '0;
    for (int i = 0; i < BYTE_N; i++) begin
      dout[8*i +: 8] = SBOX[din[8*i +: 8]];
    end
  end

endmodule

// File: rtl/gamma_share_ctrl_arb2_rr.sv
// rtl/gamma_share_ctrl_arb2_rr.sv - two-input arbiter, round-robin or fixed RND priority
module arb2_rr
  import gamma_share_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rnd_req,
  input  logic key_req,
  output logic rnd_ack,
  output logic key_ack
);

  logic last_owner;

  always_comb begin
    rnd_ack = 1'b0;
    key_ack = 1'b0;
    if (!rst) begin
      if (rnd_req && key_req) begin
        // On a tie the requester that was not served last wins.
        if ((RR_EN != 0) && (last_owner == OWNER_RND)) begin
          key_ack = 1'b1;
        end else begin
          rnd_ack = 1'b1;
        end
      end else begin
        rnd_ack = rnd_req;
        key_ack = key_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_KEY;
    end else if (rnd_ack) begin
      last_owner <= OWNER_RND;
    end else if (key_ack) begin
      last_owner <= OWNER_KEY;
    end
  end

endmodule

// File: rtl/gamma_share_ctrl.sv
// rtl/gamma_share_ctrl.sv - shares one gamma layer between the round datapath and key schedule
module gamma_share_ctrl
  import gamma_share_pkg::*;
#(
  parameter int OUT_REG = 1,
  parameter int RR_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_req,
  input  logic [DATA_W-1:0] rnd_data,
  output logic              rnd_ack,
  input  logic              key_req,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ack,
  output logic [DATA_W-1:0] res_data,
  output logic              rnd_done,
  output logic              key_done,
  output logic              busy
);

  blk_t in_reg;
  blk_t gamma_out;
  tag_t s1;

  arb2_rr #(.RR_EN(RR_EN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .rnd_req (rnd_req),
    .key_req (key_req),
    .rnd_ack (rnd_ack),
    .key_ack (key_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg <= '0;
      s1     <= '0;
    end else begin
      s1.valid <= rnd_ack | key_ack;
      if (rnd_ack) begin
        in_reg   <= rnd_data;
        s1.owner <= OWNER_RND;
      end else if (key_ack) begin
        in_reg   <= key_data;
        s1.owner <= OWNER_KEY;
      end
    end
  end

  gamma u_gamma (
    .din  (in_reg),
    .dout (gamma_out)
  );

  if (OUT_REG != 0) begin : g_out_reg
    blk_t out_reg;
    tag_t s2;

    // out_reg only loads on a real result so res_data keeps the last one between pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_reg <= '0;
        s2      <= '0;
      end else begin
        s2 <= s1;
        if (s1.valid) begin
          out_reg <= gamma_out;
        end
      end
    end

    assign res_data = out_reg;
    assign rnd_done = s2.valid && (s2.owner == OWNER_RND);
    assign key_done = s2.valid && (s2.owner == OWNER_KEY);
    assign busy     = s1.valid | s2.valid;
  end else begin : g_comb_out
    logic loaded;

    always_ff @(posedge clk) begin
      if (rst) begin
        loaded <= 1'b0;
      end else if (s1.valid) begin
        loaded <= 1'b1;
      end
    end

    // Zero until the first operand has passed through, then gamma of the held operand.
    assign res_data = (loaded || s1.valid) ? gamma_out : '0;
    assign rnd_done = s1.valid && (s1.owner == OWNER_RND);
    assign key_done = s1.valid && (s1.owner == OWNER_KEY);
    assign busy     = s1.valid;
  end

endmodule

// File: tb/tb_gamma_share_ctrl.sv
// tb/tb_gamma_share_ctrl.sv - scoreboard bench for three gamma_share_ctrl configurations
module tb_gamma_share_ctrl;
  import gamma_share_pkg::*;

  typedef struct {
    logic         owner;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  localparam logic [127:0] R00_IN   = {16{8'h00}};
  localparam logic [127:0] R01_IN   = {16{8'h01}};
  localparam logic [127:0] R02_IN   = {16{8'h02}};
  localparam logic [127:0] RFF_IN   = {16{8'hff}};
  localparam logic [127:0] RAF_IN   = {16{8'haf}};
  localparam logic [127:0] ROW0_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ROW1_IN  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R00      = {16{8'ha7}};
  localparam logic [127:0] R01      = {16{8'hd3}};
  localparam logic [127:0] R02      = {16{8'he6}};
  localparam logic [127:0] RFF      = {16{8'h37}};
  localparam logic [127:0] RAF      = {16{8'hb2}};
  localparam logic [127:0] ROW0_OUT = 128'ha7d3e671d0ac4d793ac991fc1e4754bd;
  localparam logic [127:0] ROW1_OUT = 128'h8ca57afb63b8ddd4e5b3c5bea9880ca2;
  localparam logic [127:0] Z        = '0;

  logic         clk = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  logic         rst_i [3];
  logic         rreq  [3];
  logic         kreq  [3];
  logic [127:0] rdat  [3];
  logic [127:0] kdat  [3];
  logic         rack  [3];
  logic         kack  [3];
  logic         rdone [3];
  logic         kdone [3];
  logic         busy_o[3];
  logic [127:0] res   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: registered output + round robin, 1: fixed priority, 2: unregistered output
  gamma_share_ctrl #(.OUT_REG(1), .RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst_i[0]), .rnd_req(rreq[0]), .rnd_data(rdat[0]), .rnd_ack(rack[0]),
    .key_req(kreq[0]), .key_data(kdat[0]), .key_ack(kack[0]), .res_data(res[0]),
    .rnd_done(rdone[0]), .key_done(kdone[0]), .busy(busy_o[0]));

  gamma_share_ctrl #(.OUT_REG(1), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst_i[1]), .rnd_req(rreq[1]), .rnd_data(rdat[1]), .rnd_ack(rack[1]),
    .key_req(kreq[1]), .key_data(kdat[1]), .key_ack(kack[1]), .res_data(res[1]),
    .rnd_done(rdone[1]), .key_done(kdone[1]), .busy(busy_o[1]));

  gamma_share_ctrl #(.OUT_REG(0), .RR_EN(1)) dut_o0 (
    .clk(clk), .rst(rst_i[2]), .rnd_req(rreq[2]), .rnd_data(rdat[2]), .rnd_ack(rack[2]),
    .key_req(kreq[2]), .key_data(kdat[2]), .key_ack(kack[2]), .res_data(res[2]),
    .rnd_done(rdone[2]), .key_done(kdone[2]), .busy(busy_o[2]));

  for (genvar g = 0; g < 3; g++) begin : mon
    exp_t q[$];
    always @(negedge clk) begin
      exp_t e;
      if (rdone[g] === 1'b1 || kdone[g] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL done_spurious[%0d] cyc=%0d got rnd_done=%0b key_done=%0b required no pulse",
                   g, cyc, rdone[g], kdone[g]);
        end else begin
          e = q.pop_front();
          if ((rdone[g] && kdone[g]) || (kdone[g] !== e.owner) || (res[g] !== e.data) || (cyc != e.cyc)) begin
            failures++;
            $display("FAIL done[%0d] got cyc=%0d rnd=%0b key=%0b data=%h required cyc=%0d owner=%0b data=%h",
                     g, cyc, rdone[g], kdone[g], res[g], e.cyc, e.owner, e.data);
          end
        end
      end
    end
  end

  task automatic chk1(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0b required=%0b", name, got, req);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic push(input int id, input logic own, input logic [127:0] d, input int c);
    exp_t e;
    e.owner = own;
    e.data  = d;
    e.cyc   = c;
    case (id)
      0:       mon[0].q.push_back(e);
      1:       mon[1].q.push_back(e);
      default: mon[2].q.push_back(e);
    endcase
  endtask

  task automatic flush(input int id);
    case (id)
      0:       mon[0].q.delete();
      1:       mon[1].q.delete();
      default: mon[2].q.delete();
    endcase
  endtask

  // One cycle of stimulus on instance id; acks are checked in-cycle, results are queued.
  task automatic step(input int id, input logic rs,
                      input logic rr, input logic [127:0] rd,
                      input logic kr, input logic [127:0] kd,
                      input logic ear, input logic eak,
                      input logic [127:0] er, input logic [127:0] ek);
    int lat;
    @(posedge clk);
    #1;
    rst_i[id] = rs;
    rreq[id]  = rr;
    rdat[id]  = rd;
    kreq[id]  = kr;
    kdat[id]  = kd;
    #1;
    chk1($sformatf("rnd_ack[%0d]@%0d", id, cyc), rack[id], ear);
    chk1($sformatf("key_ack[%0d]@%0d", id, cyc), kack[id], eak);
    lat = (id == 2) ? 1 : 2;
    if (rs) flush(id);
    if (ear) push(id, OWNER_RND, er, cyc + lat);
    if (eak) push(id, OWNER_KEY, ek, cyc + lat);
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) step(id, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 1'b0, Z, Z);
  endtask

  task automatic chk_quiet(input int id, input logic eb, input logic [127:0] eres);
    @(negedge clk);
    #1;
    chk1($sformatf("busy[%0d]@%0d", id, cyc), busy_o[id], eb);
    chkv($sformatf("res_data[%0d]@%0d", id, cyc), res[id], eres);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_i[i] = 1'b1;
      rreq[i]  = 1'b0;
      kreq[i]  = 1'b0;
      rdat[i]  = '0;
      kdat[i]  = '0;
    end
    repeat (2) @(posedge clk);

    // Requests during reset must not be acknowledged
    for (int i = 0; i < 3; i++) step(i, 1'b1, 1'b1, R00_IN, 1'b1, R00_IN, 1'b0, 1'b0, Z, Z);
    for (int i = 0; i < 3; i++) step(i, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, 1'b0, Z, Z);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("reset_busy[%0d]", i), busy_o[i], 1'b0);
      chk1($sformatf("reset_rnd_done[%0d]", i), rdone[i], 1'b0);
      chk1($sformatf("reset_key_done[%0d]", i), kdone[i], 1'b0);
      chkv($sformatf("reset_res_data[%0d]", i), res[i], Z);
    end

    // Round robin tie straight after reset: RND, KEY, RND, KEY
    step(0, 1'b0, 1'b1, R01_IN, 1'b1, ROW0_IN, 1'b1, 1'b0, R01, Z);
    step(0, 1'b0, 1'b1, R01_IN, 1'b1, ROW0_IN, 1'b0, 1'b1, Z, ROW0_OUT);
    step(0, 1'b0, 1'b1, R02_IN, 1'b1, ROW1_IN, 1'b1, 1'b0, R02, Z);
    step(0, 1'b0, 1'b1, R02_IN, 1'b1, ROW1_IN, 1'b0, 1'b1, Z, ROW1_OUT);
    idle(0, 3);

    // Back-to-back RND operations
    step(0, 1'b0, 1'b1, R00_IN, 1'b0, Z, 1'b1, 1'b0, R00, Z);
    step(0, 1'b0, 1'b1, R01_IN, 1'b0, Z, 1'b1, 1'b0, R01, Z);
    step(0, 1'b0, 1'b1, R02_IN, 1'b0, Z, 1'b1, 1'b0, R02, Z);
    idle(0, 1);
    chk_quiet(0, 1'b1, R01);
    idle(0, 2);
    chk_quiet(0, 1'b0, R02);

    // Single KEY op, then a tie goes to RND while KEY waits
    step(0, 1'b0, 1'b0, Z, 1'b1, RFF_IN, 1'b0, 1'b1, Z, RFF);
    idle(0, 1);
    step(0, 1'b0, 1'b1, RAF_IN, 1'b1, ROW0_IN, 1'b1, 1'b0, RAF, Z);
    step(0, 1'b0, 1'b0, Z, 1'b1, ROW0_IN, 1'b0, 1'b1, Z, ROW0_OUT);
    idle(0, 3);

    // Reset one cycle after a KEY accept: no done, everything cleared
    step(0, 1'b0, 1'b0, Z, 1'b1, ROW1_IN, 1'b0, 1'b1, Z, ROW1_OUT);
    step(0, 1'b1, 1'b0, Z, 1'b0, Z, 1'b0, 1'b0, Z, Z);
    idle(0, 1);
    chk_quiet(0, 1'b0, Z);

    // RND accept then reset: the pointer must return to KEY so the next tie goes to RND
    step(0, 1'b0, 1'b1, R00_IN, 1'b0, Z, 1'b1, 1'b0, R00, Z);
    step(0, 1'b1, 1'b0, Z, 1'b0, Z, 1'b0, 1'b0, Z, Z);
    idle(0, 1);
    step(0, 1'b0, 1'b1, RAF_IN, 1'b1, ROW1_IN, 1'b1, 1'b0, RAF, Z);
    step(0, 1'b0, 1'b0, Z, 1'b1, ROW1_IN, 1'b0, 1'b1, Z, ROW1_OUT);
    idle(0, 3);
    chk_quiet(0, 1'b0, ROW1_OUT);

    // Fixed priority: RND wins every tie, KEY served once RND drops
    step(1, 1'b0, 1'b1, R00_IN, 1'b1, ROW0_IN, 1'b1, 1'b0, R00, Z);
    step(1, 1'b0, 1'b1, R01_IN, 1'b1, ROW0_IN, 1'b1, 1'b0, R01, Z);
    step(1, 1'b0, 1'b1, R02_IN, 1'b1, ROW0_IN, 1'b1, 1'b0, R02, Z);
    step(1, 1'b0, 1'b0, Z, 1'b1, ROW0_IN, 1'b0, 1'b1, Z, ROW0_OUT);
    idle(1, 3);
    chk_quiet(1, 1'b0, ROW0_OUT);

    // Unregistered output: one-cycle latency
    step(2, 1'b0, 1'b0, Z, 1'b1, R00_IN, 1'b0, 1'b1, Z, R00);
    idle(2, 1);
    step(2, 1'b0, 1'b1, ROW1_IN, 1'b1, RFF_IN, 1'b1, 1'b0, ROW1_OUT, Z);
    step(2, 1'b0, 1'b1, ROW1_IN, 1'b1, RFF_IN, 1'b0, 1'b1, Z, RFF);
    idle(2, 3);
    chk_quiet(2, 1'b0, RFF);

    idle(0, 2);
    checks++;
    if (mon[0].q.size() + mon[1].q.size() + mon[2].q.size() != 0) begin
      failures++;
      $display("FAIL pending_results got=%0d/%0d/%0d required=0/0/0",
               mon[0].q.size(), mon[1].q.size(), mon[2].q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
